// File: rtl/trace_buffer_dumper.sv
// Read-side controller for the circular trace buffer: freezes tracing, walks
// RAM port B from oldest to newest entry and streams each word out over
// valid/ready with a 2-entry buffer that hides the 1-cycle RAM latency.
module trace_buffer_dumper #(
  parameter  int N          = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int TB_SIZE    = 64,
  localparam int MEM_WIDTH  = N * DATA_WIDTH,
  localparam int AW         = $clog2(TB_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             dump_start,
  input  logic [AW-1:0]                    tb_wr_ptr,
  input  logic                             tb_wrapped,
  output logic                             tracing,
  output logic [AW-1:0]                    rd_address,
  input  logic [MEM_WIDTH-1:0]             rd_data,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic                             valid_out,
  input  logic                             ready_in,
  output logic                             last_out,
  output logic                             dump_done
);

  typedef enum logic [1:0] {IDLE, DUMP, DRAIN, DONE} state_t;

  state_t                 r_state, w_next;
  logic [AW:0]            r_count, r_issued, r_accepted;
  logic [AW-1:0]          r_rd_addr;
  logic                   r_pend, r_pend_last;
  logic [MEM_WIDTH-1:0]   r_out, r_skid;
  logic                   r_valid, r_last, r_skid_v, r_skid_last;

  logic                   w_start, w_pop, w_issue, w_issue_last;
  logic [AW:0]            w_outstanding;

  assign w_start       = (r_state == IDLE) && dump_start;
  assign w_pop         = r_valid && ready_in;
  // Entries issued but not yet accepted, crediting a transfer happening now
  // so a full-rate stream keeps issuing every cycle.
  assign w_outstanding = r_issued - r_accepted - {{AW{1'b0}}, w_pop};
  assign w_issue       = (r_state == DUMP) && (r_issued != r_count) &&
                         (w_outstanding < (AW+1)'(2));
  assign w_issue_last  = (r_issued + (AW+1)'(1)) == r_count;

  // Next-state and state-decoded outputs. An empty dump spends one cycle in
  // DUMP so the freeze is visible and dump_done lands two cycles after the request.
  always_comb begin
    w_next    = r_state;
    tracing   = 1'b1;
    dump_done = 1'b0;
    case (r_state)
      IDLE:  if (dump_start) w_next = DUMP;
      DUMP: begin
        tracing = 1'b0;
        if (r_count == '0)                 w_next = DONE;
        else if (w_issue && w_issue_last)  w_next = DRAIN;
      end
      DRAIN: begin
        tracing = 1'b0;
        if (w_pop && r_last) w_next = DONE;
      end
      DONE: begin
        dump_done = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, pointer sampling and read issue counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_issued    <= '0;
      r_accepted  <= '0;
      r_rd_addr   <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_count    <= tb_wrapped ? (AW+1)'(TB_SIZE) : {1'b0, tb_wr_ptr};
        r_rd_addr  <= tb_wrapped ? tb_wr_ptr : '0;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_issue) begin
          r_rd_addr <= r_rd_addr + AW'(1);
          r_issued  <= r_issued + (AW+1)'(1);
        end
        if (w_pop) r_accepted <= r_accepted + (AW+1)'(1);
      end
      r_pend      <= w_issue;
      r_pend_last <= w_issue && w_issue_last;
    end
  end

  // Output register plus skid slot; RAM data landing while stalled parks in skid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_skid      <= '0;
      r_skid_v    <= 1'b0;
      r_skid_last <= 1'b0;
    end else if (!r_valid || w_pop) begin
      if (r_skid_v) begin
        r_out    <= r_skid;
        r_last   <= r_skid_last;
        r_valid  <= 1'b1;
        r_skid_v <= r_pend;
        if (r_pend) begin
          r_skid      <= rd_data;
          r_skid_last <= r_pend_last;
        end
      end else if (r_pend) begin
        r_out   <= rd_data;
        r_last  <= r_pend_last;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end else if (r_pend) begin
      r_skid      <= rd_data;
      r_skid_last <= r_pend_last;
      r_skid_v    <= 1'b1;
    end
  end

  assign rd_address = r_rd_addr;
  assign vector_out = r_out;
  assign valid_out  = r_valid;
  assign last_out   = r_last;

endmodule

// File: tb/tb_trace_buffer_dumper.sv
// Bench for trace_buffer_dumper: table of dump scenarios with hand-derived
// results, hand-written reset/latency sequences, and randomized dumps checked
// against a queue-based model of "oldest to newest" readout.
module tb_trace_buffer_dumper;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int TB = 8;
  localparam int AW = 3;
  localparam int MW = N * DW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              dump_start = 1'b0;
  logic [AW-1:0]     tb_wr_ptr = '0;
  logic              tb_wrapped = 1'b0;
  logic              tracing;
  logic [AW-1:0]     rd_address;
  logic [MW-1:0]     rd_data;
  logic [N-1:0][DW-1:0] vector_out;
  logic              valid_out;
  logic              ready_in = 1'b0;
  logic              last_out;
  logic              dump_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [MW-1:0] mem [TB];

  trace_buffer_dumper #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TB)) dut (
    .clk(clk), .reset(reset), .dump_start(dump_start), .tb_wr_ptr(tb_wr_ptr),
    .tb_wrapped(tb_wrapped), .tracing(tracing), .rd_address(rd_address),
    .rd_data(rd_data), .vector_out(vector_out), .valid_out(valid_out),
    .ready_in(ready_in), .last_out(last_out), .dump_done(dump_done));

  always #5 clk = ~clk;

  // RAM port B: registered read, data valid one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_address];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      default: return 1'($urandom);
    endcase
  endfunction

  // One dump, cycle 0 = the cycle dump_start is high. Returns transfer count
  // and low byte of the first word and of the word flagged last.
  task automatic run_dump(input int ptr, input bit wr, input int mode, input bit poke,
                          output int n_xfer, output int first_lo, output int last_lo);
    int cnt, start, dones, done_cyc, last_cyc, first_cyc;
    logic [MW-1:0] exp_q [$];
    logic pv, pr, pl;
    logic [MW-1:0] pvec;
    cnt   = wr ? TB : ptr;
    start = wr ? ptr : 0;
    for (int k = 0; k < cnt; k++) exp_q.push_back(mem[(start + k) % TB]);
    n_xfer = 0; first_lo = -1; last_lo = -1;
    dones = 0; done_cyc = -1; last_cyc = -1; first_cyc = -1;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pvec = '0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        dump_start = 1'b1; tb_wr_ptr = AW'(ptr); tb_wrapped = wr;
      end else begin
        dump_start = poke && (c == 5);
        tb_wr_ptr  = AW'($urandom);
        tb_wrapped = 1'($urandom);
      end
      ready_in = rdy(mode, c);
      @(negedge clk);
      if (pv && !pr)
        chk("hold_while_stalled", {valid_out, last_out, vector_out}, {1'b1, pl, pvec});
      if (valid_out && ready_in) begin
        if (n_xfer < cnt) begin
          chk("data", vector_out, exp_q[n_xfer]);
          chk("last_flag", last_out, n_xfer == cnt - 1);
        end else chk("extra_transfer", n_xfer, cnt);
        if (first_cyc < 0) begin first_cyc = c; first_lo = int'(vector_out[0]); end
        if (last_out) last_lo = int'(vector_out[0]);
        n_xfer++;
        last_cyc = c;
      end
      if (dump_done) begin
        dones++;
        if (dones == 1) done_cyc = c;
      end
      chk("tracing", tracing, (c == 0) || (dones > 0));
      pv = valid_out; pr = ready_in; pl = last_out; pvec = vector_out;
      if (dones > 0 && c >= done_cyc + 3) break;
    end
    dump_start = 1'b0;
    chk("xfer_count", n_xfer, cnt);
    chk("dump_done_pulses", dones, 1);
    chk("done_cycle", done_cyc, (cnt == 0) ? 2 : last_cyc + 1);
    if (mode == 0 && cnt > 0) begin
      chk("first_valid_cycle", first_cyc, 3);
      chk("stream_back_to_back", last_cyc, 2 + cnt);
    end
  endtask

  typedef struct {
    int ptr; bit wr; int mode; bit poke;
    int e_cnt; int e_first; int e_last;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int nx, fl, ll, cnt3;
    for (int i = 0; i < TB; i++) mem[i] = {8'(i + 1), 8'(i)};

    tbl[0] = '{3, 1'b0, 0, 1'b0, 3, 0, 2};   // no wrap
    tbl[1] = '{5, 1'b1, 0, 1'b0, 8, 5, 4};   // wrapped
    tbl[2] = '{5, 1'b1, 1, 1'b0, 8, 5, 4};   // back-pressure 1,0,0,1
    tbl[3] = '{0, 1'b0, 0, 1'b0, 0, -1, -1}; // empty
    tbl[4] = '{5, 1'b1, 0, 1'b1, 8, 5, 4};   // dump_start again mid-dump
    tbl[5] = '{7, 1'b0, 1, 1'b0, 7, 0, 6};
    tbl[6] = '{0, 1'b1, 2, 1'b0, 8, 0, 7};   // wrapped at pointer 0
    tbl[7] = '{1, 1'b0, 0, 1'b0, 1, 0, 0};   // single entry

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tracing", tracing, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_addr", rd_address, 0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_dump(tbl[i].ptr, tbl[i].wr, tbl[i].mode, tbl[i].poke, nx, fl, ll);
      chk($sformatf("tbl%0d_count", i), nx, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_first_addr", i), fl, tbl[i].e_first);
      chk($sformatf("tbl%0d_last_addr", i), ll, tbl[i].e_last);
    end

    // Reset right after the 3rd accepted entry of a wrapped dump.
    @(posedge clk); #1;
    dump_start = 1'b1; tb_wr_ptr = 3'd5; tb_wrapped = 1'b1; ready_in = 1'b1;
    cnt3 = 0;
    for (int c = 0; c < 50 && cnt3 < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; dump_start = 1'b0; end
      @(negedge clk);
      if (valid_out && ready_in) cnt3++;
    end
    dump_start = 1'b0;
    chk("reset_wait_3_xfers", cnt3, 3);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midreset_valid", valid_out, 0);
    chk("midreset_tracing", tracing, 1);
    chk("midreset_done", dump_done, 0);
    chk("midreset_addr", rd_address, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_dump(2, 1'b0, 0, 1'b0, nx, fl, ll);
    chk("post_reset_count", nx, 2);
    chk("post_reset_first", fl, 0);
    chk("post_reset_last", ll, 1);

    // Randomized contents, pointers and back-pressure.
    for (int i = 0; i < TB; i++) mem[i] = MW'($urandom);
    for (int t = 0; t < 25; t++) begin
      int p; bit w;
      p = $urandom_range(0, TB - 1);
      w = 1'($urandom);
      run_dump(p, w, $urandom_range(0, 2), (w || p >= 4) && 1'($urandom), nx, fl, ll);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
